stage_execute: RTL and testbench
================================

Name: stage_execute

Overview:
Execute stage of the 5-stage RV32IM pipeline. It sits between the decode stage and the data-memory stage. It resolves operand forwarding, computes ALU/MUL results and branch/jump redirects, and runs an iterative divider for DIV/DIVU/REM/REMU. Its registered execute_* outputs feed the memory stage directly.

Parameters:
XLEN, 32, datapath width (only 32 supported)
DIV_CYCLES, 32, radix-2 divider iterations (must equal XLEN)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
decode_valid  in  1  decode holds a real instruction
decode_rs1_data  in  32  regfile rs1 value
decode_rs2_data  in  32  regfile rs2 value
decode_imm  in  32  sign-extended immediate
decode_instr_addr  in  32  instruction PC
decode_instr_addr_plus  in  32  PC+4
decode_rd  in  5  destination register
decode_alu_op  in  5  alu_op_t operation
decode_alu_src  in  2  bit1: A=PC (else rs1); bit0: B=imm (else rs2)
decode_funct3  in  3  funct3 (branch compare, load/store size)
decode_ctrl  in  7  {regfile_wr_enable, datamem_wr_enable, result_src[1:0], jump, jalr, branch}
fwd_a_sel  in  2  00 regfile, 01 writeback_result, 10 mem_alu_result, 11 regfile
fwd_b_sel  in  2  same encoding for rs2
mem_alu_result  in  32  forwarded memory-stage ALU result
writeback_result  in  32  forwarded writeback value
execute_flush  in  1  kill the instruction in decode and abort the divider
execute_busy  out  1  stall request to fetch/decode (combinational)
execute_pc_src  out  1  redirect fetch (combinational)
execute_pc_target  out  32  redirect address (combinational)
execute_rd  out  5  registered rd
execute_regfile_wr_enable  out  1  registered
execute_alu_result  out  32  registered result / memory address
execute_instr_addr_plus  out  32  registered PC+4
execute_result_src  out  2  registered
execute_datamem_wr_enable  out  1  registered
execute_funct3  out  3  registered
execute_wr_datamem_data  out  32  registered forwarded rs2 (store data)

Behaviour:
- Reset (asynchronous): all registered outputs are 0, the divider FSM goes to IDLE, and execute_busy is 0.
- Operand A/B:
  - Apply forwarding first.
  - Then apply decode_alu_src: A is PC or fwd rs1; B is imm or fwd rs2.
  - Store data is always fwd rs2.
- Single-cycle ops:
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - PASSB (LUI).
  - MUL (low 32 bits), MULH, MULHSU, MULHU (high 32 bits of the 64-bit signed/unsigned product).
  - Shifts use B[4:0].
- Branch compare uses fwd rs1 vs fwd rs2 and funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- execute_pc_src = decode_valid & !execute_flush & (jump | branch & cond).
- execute_pc_target is (fwd rs1 + imm) & ~1 when jalr, else PC + imm.
- Pipeline register, updated every edge:
  - It captures the decode values when decode_valid & !busy & !flush.
  - Otherwise it loads a bubble: both write enables 0 and the other fields 0.
- Divider FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when decode_valid & div-op & !flush. This loads the |dividend| and |divisor| and signs.
  - RUN iterates DIV_CYCLES times (counter 0..31), then moves to DONE.
  - DONE -> IDLE unconditionally.
  - execute_busy = decode_valid & div-op & (state != DONE).
- Divide latency: a div op present in cycle T gives execute outputs valid after edge T+34, with 33 stall cycles.
- Divide special cases (full latency still applies):
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = dividend.
  - 0x80000000 / -1 (signed): quotient = 0x80000000, remainder = 0.
- Divide signs: the quotient is negated if the operand signs differ (signed ops only). The remainder takes the dividend's sign.
- Flush in any FSM state forces IDLE on the next edge and drops busy the same cycle. A flush while busy inserts a bubble.
- A flush with no div op in flight only bubbles the register.

Decomposition:
- Package execute_pkg holds:
  - alu_op_t enum (5-bit): ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10, MUL 11, MULH 12, MULHSU 13, MULHU 14, DIV 15, DIVU 16, REM 17, REMU 18.
  - fwd_sel_t.
  - decode_ctrl bit indices.
  - div_state_t.
- One sub-module, execute_divider, holds the FSM, the restoring shift-subtract datapath and the sign/special-case fixup. Its interface is start, flush, op (2-bit), a, b, done, result.

Test Plan:
- ADD with fwd_a_sel=10, mem_alu_result=5, rs2=7, alu_src=00 -> execute_alu_result=12 one edge later, and regfile_wr_enable follows decode.
- BLT with rs1=0xFFFFFFFF, rs2=1, PC=0x40, imm=0x10 -> pc_src=1 and pc_target=0x50 in the same cycle. BLTU with the same operands -> pc_src=0.
- JALR with rs1=0x103, imm=4 -> pc_target=0x106, execute_instr_addr_plus=PC+4.
- DIV -7/2 -> busy high 33 cycles, then result 0xFFFFFFFD. REM gives 0xFFFFFFFF. DIVU by 0 -> 0xFFFFFFFF. DIV 0x80000000/-1 -> 0x80000000.
- Start DIV, assert execute_flush at cycle 10 -> busy drops the same cycle, the FSM is IDLE next edge, and a bubble is output. A following ADD completes normally.
- Assert rst mid-division and mid-instruction -> all execute_* outputs 0 immediately and busy 0.

Source files
------------

// File: rtl/stage_execute_pkg.sv
// Shared types for the RV32IM execute stage: ALU opcodes, forwarding selects,
// decode control bit positions and the divider state/op encodings.
package execute_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_WB     = 2'b01,
    FWD_MEM    = 2'b10,
    FWD_RF_ALT = 2'b11
  } fwd_sel_t;

  // decode_ctrl = {regfile_wr_enable, datamem_wr_enable, result_src[1:0], jump, jalr, branch}
  localparam int CTRL_BRANCH  = 0;
  localparam int CTRL_JALR    = 1;
  localparam int CTRL_JUMP    = 2;
  localparam int CTRL_RSRC_LO = 3;
  localparam int CTRL_RSRC_HI = 4;
  localparam int CTRL_DM_WE   = 5;
  localparam int CTRL_RF_WE   = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  typedef enum logic [1:0] {
    DOP_DIV  = 2'd0,
    DOP_DIVU = 2'd1,
    DOP_REM  = 2'd2,
    DOP_REMU = 2'd3
  } div_op_t;

  function automatic logic is_div_op(alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic div_op_t to_div_op(alu_op_t op);
    case (op)
      ALU_DIVU: return DOP_DIVU;
      ALU_REM:  return DOP_REM;
      ALU_REMU: return DOP_REMU;
      default:  return DOP_DIV;
    endcase
  endfunction

endpackage

// File: rtl/stage_execute_if.sv
// Decode-to-execute and execute-to-memory signal bundle; the execute stage
// uses the slave view, the decode/memory side (or a bench) the master view.
interface stage_execute_if #(
  parameter int XLEN = 32
);
  logic            decode_valid;
  logic [XLEN-1:0] decode_rs1_data;
  logic [XLEN-1:0] decode_rs2_data;
  logic [XLEN-1:0] decode_imm;
  logic [XLEN-1:0] decode_instr_addr;
  logic [XLEN-1:0] decode_instr_addr_plus;
  logic [4:0]      decode_rd;
  logic [4:0]      decode_alu_op;
  logic [1:0]      decode_alu_src;
  logic [2:0]      decode_funct3;
  logic [6:0]      decode_ctrl;
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] writeback_result;
  logic            execute_flush;
  logic            execute_busy;
  logic            execute_pc_src;
  logic [XLEN-1:0] execute_pc_target;
  logic [4:0]      execute_rd;
  logic            execute_regfile_wr_enable;
  logic [XLEN-1:0] execute_alu_result;
  logic [XLEN-1:0] execute_instr_addr_plus;
  logic [1:0]      execute_result_src;
  logic            execute_datamem_wr_enable;
  logic [2:0]      execute_funct3;
  logic [XLEN-1:0] execute_wr_datamem_data;

  modport master (
    output decode_valid, decode_rs1_data, decode_rs2_data, decode_imm,
           decode_instr_addr, decode_instr_addr_plus, decode_rd, decode_alu_op,
           decode_alu_src, decode_funct3, decode_ctrl, fwd_a_sel, fwd_b_sel,
           mem_alu_result, writeback_result, execute_flush,
    input  execute_busy, execute_pc_src, execute_pc_target, execute_rd,
           execute_regfile_wr_enable, execute_alu_result, execute_instr_addr_plus,
           execute_result_src, execute_datamem_wr_enable, execute_funct3,
           execute_wr_datamem_data
  );

  modport slave (
    input  decode_valid, decode_rs1_data, decode_rs2_data, decode_imm,
           decode_instr_addr, decode_instr_addr_plus, decode_rd, decode_alu_op,
           decode_alu_src, decode_funct3, decode_ctrl, fwd_a_sel, fwd_b_sel,
           mem_alu_result, writeback_result, execute_flush,
    output execute_busy, execute_pc_src, execute_pc_target, execute_rd,
           execute_regfile_wr_enable, execute_alu_result, execute_instr_addr_plus,
           execute_result_src, execute_datamem_wr_enable, execute_funct3,
           execute_wr_datamem_data
  );
endinterface

// File: rtl/stage_execute_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU: magnitudes in,
// one quotient bit per cycle, sign and divide-by-zero fixup while in DONE.
module execute_divider
  import execute_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  div_op_t         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int               CNT_W    = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             sel_rem_q, sel_rem_d;
  logic             dz_q, dz_d;

  logic            is_signed, a_neg, b_neg;
  logic [XLEN:0]   rem_shift, trial;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign is_signed = (op_i == DOP_DIV) || (op_i == DOP_REM);
  assign a_neg     = is_signed & a_i[XLEN-1];
  assign b_neg     = is_signed & b_i[XLEN-1];
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;
    dz_d      = dz_q;
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          state_d   = DIV_RUN;
          cnt_d     = '0;
          quo_d     = a_neg ? -a_i : a_i;
          rem_d     = '0;
          dvs_d     = b_neg ? -b_i : b_i;
          dvd_d     = a_i;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          sel_rem_d = (op_i == DOP_REM) || (op_i == DOP_REMU);
          dz_d      = (b_i == '0);
        end
      end
      DIV_RUN: begin
        // quo_q doubles as the dividend shifter: its MSB feeds the partial remainder
        quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
        rem_d = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (flush_i) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    quo_q     <= quo_d;
    rem_q     <= rem_d;
    dvs_q     <= dvs_d;
    dvd_q     <= dvd_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    sel_rem_q <= sel_rem_d;
    dz_q      <= dz_d;
  end

  // Signed overflow (MIN / -1) falls out naturally: |MIN|/1 negated is MIN, remainder 0
  always_comb begin
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
    if (dz_q) begin
      quo_fix = '1;
      rem_fix = dvd_q;
    end
    result_o = sel_rem_q ? rem_fix : quo_fix;
  end

  assign done_o = (state_q == DIV_DONE);

endmodule

// File: rtl/stage_execute.sv
// RV32IM execute stage: operand forwarding, ALU/multiplier, branch and jump
// redirect, iterative divide with stall, and the execute/memory pipeline register.
module stage_execute
  import execute_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input logic           clk,
  input logic           rst,
  stage_execute_if.slave bus
);
  alu_op_t                op;
  logic [XLEN-1:0]        rs1_fwd, rs2_fwd, opa, opb;
  logic signed [XLEN-1:0] rs1_s, rs2_s, opa_s, opb_s;
  logic [4:0]             shamt;
  logic [XLEN:0]          mul_a, mul_b;
  logic [2*XLEN-1:0]      prod;
  logic [XLEN-1:0]        alu_res, div_res;
  logic                   is_div, div_done, busy, capture, br_taken;

  logic [4:0]      rd_q, rd_d;
  logic            rf_we_q, rf_we_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] pc_plus_q, pc_plus_d;
  logic [1:0]      rsrc_q, rsrc_d;
  logic            dm_we_q, dm_we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] st_data_q, st_data_d;

  assign op = alu_op_t'(bus.decode_alu_op);

  always_comb begin
    case (fwd_sel_t'(bus.fwd_a_sel))
      FWD_WB:  rs1_fwd = bus.writeback_result;
      FWD_MEM: rs1_fwd = bus.mem_alu_result;
      default: rs1_fwd = bus.decode_rs1_data;
    endcase
    case (fwd_sel_t'(bus.fwd_b_sel))
      FWD_WB:  rs2_fwd = bus.writeback_result;
      FWD_MEM: rs2_fwd = bus.mem_alu_result;
      default: rs2_fwd = bus.decode_rs2_data;
    endcase
  end

  assign opa   = bus.decode_alu_src[1] ? bus.decode_instr_addr : rs1_fwd;
  assign opb   = bus.decode_alu_src[0] ? bus.decode_imm : rs2_fwd;
  assign rs1_s = rs1_fwd;
  assign rs2_s = rs2_fwd;
  assign opa_s = opa;
  assign opb_s = opb;
  assign shamt = opb[4:0];

  // One shared 33x33 multiplier; the extra bit selects signed/unsigned per operand
  assign mul_a = {((op == ALU_MULH) || (op == ALU_MULHSU)) & opa[XLEN-1], opa};
  assign mul_b = {(op == ALU_MULH) & opb[XLEN-1], opb};
  assign prod  = {{(XLEN-1){mul_a[XLEN]}}, mul_a} * {{(XLEN-1){mul_b[XLEN]}}, mul_b};

  always_comb begin
    case (op)
      ALU_ADD:    alu_res = opa + opb;
      ALU_SUB:    alu_res = opa - opb;
      ALU_SLL:    alu_res = opa << shamt;
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, opa_s < opb_s};
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, opa < opb};
      ALU_XOR:    alu_res = opa ^ opb;
      ALU_SRL:    alu_res = opa >> shamt;
      ALU_SRA:    alu_res = opa_s >>> shamt;
      ALU_OR:     alu_res = opa | opb;
      ALU_AND:    alu_res = opa & opb;
      ALU_PASSB:  alu_res = opb;
      ALU_MUL:    alu_res = prod[XLEN-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  alu_res = prod[2*XLEN-1:XLEN];
      ALU_DIV,
      ALU_DIVU,
      ALU_REM,
      ALU_REMU:   alu_res = div_res;
      default:    alu_res = '0;
    endcase
  end

  always_comb begin
    case (bus.decode_funct3)
      3'b000:  br_taken = (rs1_fwd == rs2_fwd);
      3'b001:  br_taken = (rs1_fwd != rs2_fwd);
      3'b100:  br_taken = (rs1_s < rs2_s);
      3'b101:  br_taken = (rs1_s >= rs2_s);
      3'b110:  br_taken = (rs1_fwd < rs2_fwd);
      3'b111:  br_taken = (rs1_fwd >= rs2_fwd);
      default: br_taken = 1'b0;
    endcase
  end

  assign bus.execute_pc_src = bus.decode_valid & ~bus.execute_flush &
                              (bus.decode_ctrl[CTRL_JUMP] | (bus.decode_ctrl[CTRL_BRANCH] & br_taken));
  assign bus.execute_pc_target = bus.decode_ctrl[CTRL_JALR] ? ((rs1_fwd + bus.decode_imm) & ~XLEN'(1))
                                                            : (bus.decode_instr_addr + bus.decode_imm);

  assign is_div  = is_div_op(op);
  assign busy    = ~rst & bus.decode_valid & is_div & ~div_done & ~bus.execute_flush;
  assign capture = bus.decode_valid & ~busy & ~bus.execute_flush;
  assign bus.execute_busy = busy;

  execute_divider #(
    .XLEN       (XLEN),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start_i  (bus.decode_valid & is_div & ~bus.execute_flush),
    .flush_i  (bus.execute_flush),
    .op_i     (to_div_op(op)),
    .a_i      (rs1_fwd),
    .b_i      (rs2_fwd),
    .done_o   (div_done),
    .result_o (div_res)
  );

  // Execute/memory boundary: anything not captured becomes a bubble
  always_comb begin
    rd_d      = '0;
    rf_we_d   = 1'b0;
    alu_d     = '0;
    pc_plus_d = '0;
    rsrc_d    = '0;
    dm_we_d   = 1'b0;
    funct3_d  = '0;
    st_data_d = '0;
    if (capture) begin
      rd_d      = bus.decode_rd;
      rf_we_d   = bus.decode_ctrl[CTRL_RF_WE];
      alu_d     = alu_res;
      pc_plus_d = bus.decode_instr_addr_plus;
      rsrc_d    = bus.decode_ctrl[CTRL_RSRC_HI:CTRL_RSRC_LO];
      dm_we_d   = bus.decode_ctrl[CTRL_DM_WE];
      funct3_d  = bus.decode_funct3;
      st_data_d = rs2_fwd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q      <= '0;
      rf_we_q   <= 1'b0;
      alu_q     <= '0;
      pc_plus_q <= '0;
      rsrc_q    <= '0;
      dm_we_q   <= 1'b0;
      funct3_q  <= '0;
      st_data_q <= '0;
    end else begin
      rd_q      <= rd_d;
      rf_we_q   <= rf_we_d;
      alu_q     <= alu_d;
      pc_plus_q <= pc_plus_d;
      rsrc_q    <= rsrc_d;
      dm_we_q   <= dm_we_d;
      funct3_q  <= funct3_d;
      st_data_q <= st_data_d;
    end
  end

  assign bus.execute_rd                = rd_q;
  assign bus.execute_regfile_wr_enable = rf_we_q;
  assign bus.execute_alu_result        = alu_q;
  assign bus.execute_instr_addr_plus   = pc_plus_q;
  assign bus.execute_result_src        = rsrc_q;
  assign bus.execute_datamem_wr_enable = dm_we_q;
  assign bus.execute_funct3            = funct3_q;
  assign bus.execute_wr_datamem_data   = st_data_q;

endmodule

// File: tb/tb_stage_execute.sv
// Directed bench for the execute stage: forwarding, ALU/MUL ops, branches,
// JALR, divider latency and special cases, flush and asynchronous reset.
module tb_stage_execute;
  import execute_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stage_execute_if #(.XLEN(32)) bus();

  stage_execute #(.XLEN(32), .DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] C_ALU   = 7'b1000000;
  localparam logic [6:0] C_STORE = 7'b0100000;
  localparam logic [6:0] C_BR    = 7'b0000001;
  localparam logic [6:0] C_JALR  = 7'b1010110;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.decode_valid           = 1'b0;
    bus.decode_rs1_data        = '0;
    bus.decode_rs2_data        = '0;
    bus.decode_imm             = '0;
    bus.decode_instr_addr      = '0;
    bus.decode_instr_addr_plus = '0;
    bus.decode_rd              = '0;
    bus.decode_alu_op          = '0;
    bus.decode_alu_src         = '0;
    bus.decode_funct3          = '0;
    bus.decode_ctrl            = '0;
    bus.fwd_a_sel              = '0;
    bus.fwd_b_sel              = '0;
    bus.mem_alu_result         = '0;
    bus.writeback_result       = '0;
    bus.execute_flush          = 1'b0;
  endtask

  task automatic drive(input alu_op_t op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [1:0] src, input logic [2:0] f3, input logic [6:0] ctrl);
    bus.decode_valid           = 1'b1;
    bus.decode_rs1_data        = rs1;
    bus.decode_rs2_data        = rs2;
    bus.decode_imm             = imm;
    bus.decode_instr_addr      = pc;
    bus.decode_instr_addr_plus = pc + 32'd4;
    bus.decode_rd              = rd;
    bus.decode_alu_op          = op;
    bus.decode_alu_src         = src;
    bus.decode_funct3          = f3;
    bus.decode_ctrl            = ctrl;
    bus.fwd_a_sel              = 2'b00;
    bus.fwd_b_sel              = 2'b00;
    bus.execute_flush          = 1'b0;
  endtask

  task automatic test_reset();
    drive(ALU_DIV, 32'd100, 32'd7, 32'd0, 32'h10, 5'd1, 2'b00, 3'b000, C_ALU);
    #2;
    n_checks++;
    if (bus.execute_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.execute_busy); end
    n_checks++;
    if (bus.execute_alu_result !== 32'd0) begin n_fail++; $display("FAIL reset_alu_result: got %h expected 0", bus.execute_alu_result); end
    n_checks++;
    if (bus.execute_regfile_wr_enable !== 1'b0 || bus.execute_rd !== 5'd0) begin
      n_fail++; $display("FAIL reset_rf_we_rd: got we=%b rd=%0d expected 0/0", bus.execute_regfile_wr_enable, bus.execute_rd);
    end
    n_checks++;
    if (bus.execute_instr_addr_plus !== 32'd0 || bus.execute_wr_datamem_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_plus_store: got %h/%h expected 0/0", bus.execute_instr_addr_plus, bus.execute_wr_datamem_data);
    end
    idle_inputs();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_forward_add();
    drive(ALU_ADD, 32'd99, 32'd7, 32'd0, 32'h100, 5'd3, 2'b00, 3'b000, C_ALU);
    bus.fwd_a_sel      = 2'b10;
    bus.mem_alu_result = 32'd5;
    #1;
    n_checks++;
    if (bus.execute_busy !== 1'b0 || bus.execute_pc_src !== 1'b0) begin
      n_fail++; $display("FAIL add_comb: got busy=%b pc_src=%b expected 0/0", bus.execute_busy, bus.execute_pc_src);
    end
    tick();
    n_checks++;
    if (bus.execute_alu_result !== 32'd12) begin n_fail++; $display("FAIL fwd_mem_add: got %h expected %h", bus.execute_alu_result, 32'd12); end
    n_checks++;
    if (bus.execute_regfile_wr_enable !== 1'b1 || bus.execute_rd !== 5'd3) begin
      n_fail++; $display("FAIL add_rf_we_rd: got we=%b rd=%0d expected 1/3", bus.execute_regfile_wr_enable, bus.execute_rd);
    end
    n_checks++;
    if (bus.execute_instr_addr_plus !== 32'h104) begin n_fail++; $display("FAIL add_plus: got %h expected 104", bus.execute_instr_addr_plus); end

    drive(ALU_SUB, 32'd10, 32'd99, 32'd0, 32'h200, 5'd4, 2'b00, 3'b010, C_STORE);
    bus.fwd_b_sel        = 2'b01;
    bus.writeback_result = 32'd3;
    tick();
    n_checks++;
    if (bus.execute_alu_result !== 32'd7) begin n_fail++; $display("FAIL fwd_wb_sub: got %h expected 7", bus.execute_alu_result); end
    n_checks++;
    if (bus.execute_wr_datamem_data !== 32'd3 || bus.execute_datamem_wr_enable !== 1'b1 ||
        bus.execute_regfile_wr_enable !== 1'b0 || bus.execute_funct3 !== 3'b010) begin
      n_fail++; $display("FAIL store_fields: got data=%h dm_we=%b rf_we=%b f3=%b expected 3/1/0/010",
                         bus.execute_wr_datamem_data, bus.execute_datamem_wr_enable,
                         bus.execute_regfile_wr_enable, bus.execute_funct3);
    end

    drive(ALU_ADD, 32'd5, 32'd6, 32'h20, 32'h1000, 5'd1, 2'b11, 3'b000, C_ALU);
    tick();
    n_checks++;
    if (bus.execute_alu_result !== 32'h1020) begin n_fail++; $display("FAIL pc_plus_imm: got %h expected 1020", bus.execute_alu_result); end
  endtask

  task automatic test_alu();
    alu_op_t     ops [14] = '{ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
                              ALU_OR, ALU_AND, ALU_PASSB, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    logic [31:0] av [14]  = '{32'd3, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000F0F0, 32'h80000000,
                              32'h80000000, 32'hF0, 32'hF0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE,
                              32'd2, 32'hFFFFFFFF};
    logic [31:0] bv [14]  = '{32'd5, 32'h23, 32'd1, 32'd1, 32'h0000FF00, 32'd4, 32'h24, 32'h0F,
                              32'h3C, 32'h12345000, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev [14]  = '{32'hFFFFFFFE, 32'd8, 32'd1, 32'd0, 32'h00000FF0, 32'h08000000,
                              32'hF8000000, 32'hFF, 32'h30, 32'h12345000, 32'd1, 32'hFFFFFFFF,
                              32'd1, 32'hFFFFFFFE};
    for (int i = 0; i < 14; i++) begin
      drive(ops[i], av[i], bv[i], 32'd0, 32'h400, 5'(i + 1), 2'b00, 3'b000, C_ALU);
      tick();
      n_checks++;
      if (bus.execute_alu_result !== ev[i] || bus.execute_rd !== 5'(i + 1)) begin
        n_fail++; $display("FAIL alu_%s: got %h rd=%0d expected %h rd=%0d", ops[i].name(),
                           bus.execute_alu_result, bus.execute_rd, ev[i], i + 1);
      end
    end
  endtask

  task automatic test_branch();
    drive(ALU_ADD, 32'hFFFFFFFF, 32'd1, 32'h10, 32'h40, 5'd0, 2'b00, 3'b100, C_BR);
    #1;
    n_checks++;
    if (bus.execute_pc_src !== 1'b1 || bus.execute_pc_target !== 32'h50) begin
      n_fail++; $display("FAIL blt_taken: got src=%b tgt=%h expected 1/50", bus.execute_pc_src, bus.execute_pc_target);
    end
    bus.decode_funct3 = 3'b110;
    #1;
    n_checks++;
    if (bus.execute_pc_src !== 1'b0) begin n_fail++; $display("FAIL bltu_not_taken: got %b expected 0", bus.execute_pc_src); end
    bus.decode_funct3 = 3'b111;
    #1;
    n_checks++;
    if (bus.execute_pc_src !== 1'b1) begin n_fail++; $display("FAIL bgeu_taken: got %b expected 1", bus.execute_pc_src); end
    bus.decode_funct3    = 3'b000;
    bus.fwd_a_sel        = 2'b01;
    bus.writeback_result = 32'd1;
    #1;
    n_checks++;
    if (bus.execute_pc_src !== 1'b1) begin n_fail++; $display("FAIL beq_fwd_taken: got %b expected 1", bus.execute_pc_src); end
    bus.execute_flush = 1'b1;
    #1;
    n_checks++;
    if (bus.execute_pc_src !== 1'b0) begin n_fail++; $display("FAIL branch_flushed: got %b expected 0", bus.execute_pc_src); end
    tick();
    n_checks++;
    if (bus.execute_alu_result !== 32'd0 || bus.execute_instr_addr_plus !== 32'd0) begin
      n_fail++; $display("FAIL flush_bubble: got res=%h plus=%h expected 0/0", bus.execute_alu_result, bus.execute_instr_addr_plus);
    end
    idle_inputs();
  endtask

  task automatic test_jalr();
    drive(ALU_ADD, 32'h103, 32'd0, 32'd4, 32'h200, 5'd1, 2'b01, 3'b000, C_JALR);
    #1;
    n_checks++;
    if (bus.execute_pc_src !== 1'b1 || bus.execute_pc_target !== 32'h106) begin
      n_fail++; $display("FAIL jalr_target: got src=%b tgt=%h expected 1/106", bus.execute_pc_src, bus.execute_pc_target);
    end
    tick();
    n_checks++;
    if (bus.execute_instr_addr_plus !== 32'h204 || bus.execute_result_src !== 2'd2 || bus.execute_regfile_wr_enable !== 1'b1) begin
      n_fail++; $display("FAIL jalr_link: got plus=%h rsrc=%0d we=%b expected 204/2/1",
                         bus.execute_instr_addr_plus, bus.execute_result_src, bus.execute_regfile_wr_enable);
    end
  endtask

  task automatic run_div(input alu_op_t op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
    int cyc;
    cyc = 0;
    drive(op, a, b, 32'd0, 32'h300, 5'd9, 2'b00, 3'b000, C_ALU);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus.execute_busy) break;
      cyc++;
      if (cyc == 2) begin
        n_checks++;
        if (bus.execute_regfile_wr_enable !== 1'b0) begin
          n_fail++; $display("FAIL %s_stall_bubble: got we=%b expected 0", op.name(), bus.execute_regfile_wr_enable);
        end
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (cyc != 33) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d expected 33", op.name(), cyc); end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.execute_alu_result !== expv || bus.execute_rd !== 5'd9 || bus.execute_regfile_wr_enable !== 1'b1) begin
      n_fail++; $display("FAIL %s_result: got %h rd=%0d we=%b expected %h rd=9 we=1", op.name(),
                         bus.execute_alu_result, bus.execute_rd, bus.execute_regfile_wr_enable, expv);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_div();
    run_div(ALU_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    run_div(ALU_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    run_div(ALU_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF);
    run_div(ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_div(ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0);
    run_div(ALU_REMU, 32'd100,      32'd7,        32'd2);
    run_div(ALU_REM,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9);
  endtask

  task automatic test_flush_div();
    drive(ALU_DIV, 32'd100, 32'd7, 32'd0, 32'h500, 5'd2, 2'b00, 3'b000, C_ALU);
    repeat (10) tick();
    #1;
    n_checks++;
    if (bus.execute_busy !== 1'b1) begin n_fail++; $display("FAIL div_busy_mid: got %b expected 1", bus.execute_busy); end
    bus.execute_flush = 1'b1;
    #1;
    n_checks++;
    if (bus.execute_busy !== 1'b0) begin n_fail++; $display("FAIL flush_drops_busy: got %b expected 0", bus.execute_busy); end
    tick();
    n_checks++;
    if (bus.execute_regfile_wr_enable !== 1'b0 || bus.execute_alu_result !== 32'd0) begin
      n_fail++; $display("FAIL flush_div_bubble: got we=%b res=%h expected 0/0", bus.execute_regfile_wr_enable, bus.execute_alu_result);
    end
    drive(ALU_ADD, 32'd2, 32'd3, 32'd0, 32'h600, 5'd6, 2'b00, 3'b000, C_ALU);
    #1;
    n_checks++;
    if (bus.execute_busy !== 1'b0) begin n_fail++; $display("FAIL add_after_flush_busy: got %b expected 0", bus.execute_busy); end
    tick();
    n_checks++;
    if (bus.execute_alu_result !== 32'd5 || bus.execute_rd !== 5'd6) begin
      n_fail++; $display("FAIL add_after_flush: got %h rd=%0d expected 5 rd=6", bus.execute_alu_result, bus.execute_rd);
    end
    idle_inputs();
    tick();
    run_div(ALU_DIVU, 32'd100, 32'd7, 32'd14);
  endtask

  task automatic test_reset_mid();
    drive(ALU_ADD, 32'd2, 32'd3, 32'd0, 32'h700, 5'd5, 2'b00, 3'b000, C_ALU);
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.execute_alu_result !== 32'd0 || bus.execute_regfile_wr_enable !== 1'b0 ||
        bus.execute_rd !== 5'd0 || bus.execute_instr_addr_plus !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_instr: got res=%h we=%b rd=%0d plus=%h expected all 0",
                         bus.execute_alu_result, bus.execute_regfile_wr_enable, bus.execute_rd, bus.execute_instr_addr_plus);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();

    drive(ALU_DIV, 32'd100, 32'd7, 32'd0, 32'h800, 5'd7, 2'b00, 3'b000, C_ALU);
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.execute_busy !== 1'b0 || bus.execute_alu_result !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_div: got busy=%b res=%h expected 0/0", bus.execute_busy, bus.execute_alu_result);
    end
    tick();
    n_checks++;
    if (bus.execute_busy !== 1'b0) begin n_fail++; $display("FAIL rst_held_busy: got %b expected 0", bus.execute_busy); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_div(ALU_DIV, 32'd100, 32'd7, 32'd14);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_forward_add();
    test_alu();
    test_branch();
    test_jalr();
    test_div();
    test_flush_div();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "time limit");
  end

endmodule
